// File: rtl/operand_result_mem.sv
// rtl/operand_result_mem.sv - operand/result memory responder for the approximate-multiplier controller
// Streams operands A,B,A,B,... to the controller and captures its results; host preloads and reads back.
module operand_result_mem #(
    parameter int DATA_W = 16,
    parameter int NPAIRS = 8,
    parameter int RES_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          restart,
    input  logic                          host_we,
    input  logic [$clog2(2*NPAIRS)-1:0]   host_waddr,
    input  logic [DATA_W-1:0]             host_wdata,
    input  logic [$clog2(NPAIRS)-1:0]     host_raddr,
    output logic [RES_W-1:0]              host_rdata,
    input  logic                          read,
    output logic [DATA_W-1:0]             rdata,
    output logic                          rdata_valid,
    input  logic                          write,
    input  logic [RES_W-1:0]              wdata,
    output logic [$clog2(2*NPAIRS):0]     rd_ptr,
    output logic [$clog2(NPAIRS):0]       wr_ptr,
    output logic                          busy,
    output logic                          all_written,
    output logic                          rd_overrun,
    output logic                          wr_overrun
);
    localparam int OP_AW  = $clog2(2*NPAIRS);
    localparam int RES_AW = $clog2(NPAIRS);

    localparam logic [OP_AW:0]  RD_END   = (OP_AW+1)'(2*NPAIRS);
    localparam logic [OP_AW:0]  RD_ONE   = (OP_AW+1)'(1);
    localparam logic [RES_AW:0] WR_END   = (RES_AW+1)'(NPAIRS);
    localparam logic [RES_AW:0] WR_FINAL = (RES_AW+1)'(NPAIRS-1);
    localparam logic [RES_AW:0] WR_ONE   = (RES_AW+1)'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [DATA_W-1:0] op_ram  [2*NPAIRS];
    logic [RES_W-1:0]  res_ram [NPAIRS];

    logic [1:0]        state_q, state_d;
    logic [OP_AW:0]    rd_ptr_q, rd_ptr_d;
    logic [RES_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              rd_overrun_q, rd_overrun_d;
    logic              wr_overrun_q, wr_overrun_d;
    logic [RES_W-1:0]  host_rdata_q, host_rdata_d;
    logic              op_we;
    logic              res_we;

    always_comb begin
        state_d       = state_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        rd_overrun_d  = rd_overrun_q;
        wr_overrun_d  = wr_overrun_q;
        op_we         = 1'b0;
        res_we        = 1'b0;
        // Registered read of the old contents gives read-before-write for free.
        host_rdata_d  = res_ram[host_raddr];

        if (restart) begin
            state_d      = S_IDLE;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            rd_overrun_d = 1'b0;
            wr_overrun_d = 1'b0;
        end else begin
            if (read) begin
                rdata_valid_d = 1'b1;
                if (rd_ptr_q < RD_END) begin
                    rdata_d  = op_ram[rd_ptr_q[OP_AW-1:0]];
                    rd_ptr_d = rd_ptr_q + RD_ONE;
                end else begin
                    rdata_d      = '0;
                    rd_overrun_d = 1'b1;
                end
            end

            if (write) begin
                if (wr_ptr_q < WR_END) begin
                    res_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + WR_ONE;
                end else begin
                    wr_overrun_d = 1'b1;
                end
            end

            op_we = host_we && (state_q != S_BUSY);

            case (state_q)
                S_IDLE, S_BUSY: begin
                    if (res_we && (wr_ptr_q == WR_FINAL)) begin
                        state_d = S_DONE;
                    end else if (read || write) begin
                        state_d = S_BUSY;
                    end
                end
                S_DONE:  state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            rd_overrun_q  <= 1'b0;
            wr_overrun_q  <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            rd_overrun_q  <= rd_overrun_d;
            wr_overrun_q  <= wr_overrun_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    // RAMs are not reset; a reset edge drops any write in flight.
    always_ff @(posedge clk) begin
        if (!rst && op_we) begin
            op_ram[host_waddr] <= host_wdata;
        end
        if (!rst && res_we) begin
            res_ram[wr_ptr_q[RES_AW-1:0]] <= wdata;
        end
    end

    assign host_rdata  = host_rdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign rd_ptr      = rd_ptr_q;
    assign wr_ptr      = wr_ptr_q;
    assign busy        = (state_q == S_BUSY);
    assign all_written = (state_q == S_DONE);
    assign rd_overrun  = rd_overrun_q;
    assign wr_overrun  = wr_overrun_q;

endmodule

// File: tb/tb_operand_result_mem.sv
// tb/tb_operand_result_mem.sv - directed bench for operand_result_mem with a behavioural reference model
module tb_operand_result_mem;
    logic        clk = 1'b0;
    logic        rst, restart, host_we, read, write;
    logic [3:0]  host_waddr;
    logic [15:0] host_wdata;
    logic [2:0]  host_raddr;
    logic [31:0] host_rdata, wdata;
    logic [15:0] rdata;
    logic        rdata_valid, busy, all_written, rd_overrun, wr_overrun;
    logic [4:0]  rd_ptr;
    logic [3:0]  wr_ptr;

    int errors = 0;
    int checks = 0;

    operand_result_mem #(.DATA_W(16), .NPAIRS(8), .RES_W(32)) dut (
        .clk(clk), .rst(rst), .restart(restart),
        .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
        .host_raddr(host_raddr), .host_rdata(host_rdata),
        .read(read), .rdata(rdata), .rdata_valid(rdata_valid),
        .write(write), .wdata(wdata),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .busy(busy), .all_written(all_written),
        .rd_overrun(rd_overrun), .wr_overrun(wr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arrays and counters describing what the block must do.
    logic [15:0] op_m  [16];
    logic [31:0] res_m [8];
    bit          res_known [8];
    int          m_rd, m_wr;
    bit          m_run, m_done, m_rv, m_rov, m_wov, m_hr_known, chk_en;
    logic [15:0] m_rdata;
    logic [31:0] m_hr;

    initial begin
        chk_en = 0;
        for (int i = 0; i < 8; i++) res_known[i] = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_rd = 0; m_wr = 0; m_run = 0; m_done = 0; m_rv = 0;
            m_rov = 0; m_wov = 0; m_rdata = 0; m_hr = 0; m_hr_known = 1;
            chk_en = 1;
        end else begin
            m_hr       = res_m[host_raddr];
            m_hr_known = res_known[host_raddr];
            if (restart) begin
                m_rd = 0; m_wr = 0; m_run = 0; m_done = 0; m_rv = 0; m_rov = 0; m_wov = 0;
            end else begin
                bit final_wr;
                final_wr = 0;
                m_rv = read;
                if (read) begin
                    if (m_rd < 16) begin m_rdata = op_m[m_rd]; m_rd++; end
                    else begin m_rdata = 0; m_rov = 1; end
                end
                if (host_we && !m_run) op_m[host_waddr] = host_wdata;
                if (write) begin
                    if (m_wr < 8) begin
                        res_m[m_wr] = wdata; res_known[m_wr] = 1; m_wr++;
                        final_wr = (m_wr == 8);
                    end else m_wov = 1;
                end
                if (final_wr && !m_done) begin m_done = 1; m_run = 0; end
                else if (!m_done && (read || write)) m_run = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("rdata", rdata, m_rdata);
            chk("rdata_valid", rdata_valid, m_rv);
            chk("rd_ptr", rd_ptr, m_rd);
            chk("wr_ptr", wr_ptr, m_wr);
            chk("busy", busy, m_run);
            chk("all_written", all_written, m_done);
            chk("rd_overrun", rd_overrun, m_rov);
            chk("wr_overrun", wr_overrun, m_wov);
            if (m_hr_known) chk("host_rdata", host_rdata, m_hr);
        end
    end

    task automatic cyc(input logic r, input logic w, input logic [31:0] wd);
        read = r; write = w; wdata = wd;
        @(negedge clk);
        read = 0; write = 0;
    endtask

    logic [15:0] ops [16];

    initial begin
        rst = 1; restart = 0; host_we = 0; host_waddr = 0; host_wdata = 0;
        host_raddr = 0; read = 0; write = 0; wdata = 0;
        ops[0] = 16'd3; ops[1] = 16'd5; ops[2] = 16'd7; ops[3] = 16'd2;
        for (int i = 4; i < 16; i++) ops[i] = 16'(i * 11 + 4);
        repeat (2) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset rd_ptr", rd_ptr, 0);
        chk("reset rdata_valid", rdata_valid, 0);
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            host_we = 1; host_waddr = 4'(i); host_wdata = ops[i];
            @(negedge clk);
        end
        host_we = 0;

        cyc(1, 0, 0);
        chk("read1 rdata", rdata, 3);
        chk("read1 valid", rdata_valid, 1);
        @(negedge clk);
        chk("valid one cycle", rdata_valid, 0);
        chk("rdata held", rdata, 3);
        cyc(1, 0, 0);
        chk("read2 rdata", rdata, 5);
        chk("read2 rd_ptr", rd_ptr, 2);
        chk("busy in run", busy, 1);

        host_we = 1; host_waddr = 0; host_wdata = 16'hFFFF;
        @(negedge clk);
        host_we = 0;

        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                cyc(1, 1, 32'(i * 100));
                chk("rw rd_ptr", rd_ptr, 3);
                chk("rw wr_ptr", wr_ptr, 3);
                chk("rw rdata", rdata, 7);
            end else begin
                cyc(0, 1, 32'(i * 100));
            end
        end
        chk("all_written after 8th", all_written, 1);
        chk("busy after 8th", busy, 0);
        host_raddr = 5;
        @(negedge clk);
        chk("host_rdata[5]", host_rdata, 500);

        for (int i = 3; i < 16; i++) cyc(1, 0, 0);
        chk("read16 rdata", rdata, ops[15]);
        cyc(1, 0, 0);
        chk("read17 rdata", rdata, 0);
        chk("read17 overrun", rd_overrun, 1);
        chk("read17 rd_ptr", rd_ptr, 16);

        cyc(0, 1, 32'hDEAD);
        chk("write9 overrun", wr_overrun, 1);
        for (int j = 0; j < 8; j++) begin
            host_raddr = 3'(j);
            @(negedge clk);
            @(negedge clk);
            chk("result slot", host_rdata, j * 100);
        end

        restart = 1;
        @(negedge clk);
        restart = 0;
        chk("restart busy", busy, 0);
        chk("restart rd_overrun", rd_overrun, 0);
        chk("restart wr_overrun", wr_overrun, 0);
        chk("restart all_written", all_written, 0);
        cyc(1, 0, 0);
        chk("reread idx0", rdata, 3);

        restart = 1;
        @(negedge clk);
        restart = 0;
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'(1000 + k));
        rst = 1; write = 1; wdata = 32'd9999;
        @(negedge clk);
        rst = 0; write = 0;
        chk("rst wr_ptr", wr_ptr, 0);
        chk("rst busy", busy, 0);
        chk("rst rd_overrun", rd_overrun, 0);
        chk("rst wr_overrun", wr_overrun, 0);
        chk("rst all_written", all_written, 0);
        host_raddr = 3;
        repeat (2) @(negedge clk);
        chk("dropped write slot3", host_rdata, 300);
        host_raddr = 0;
        repeat (2) @(negedge clk);
        chk("slot0 after rerun", host_rdata, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
